// File: rtl/io_pg_pkg.sv
// rtl/io_pg_pkg.sv - shared FSM states and timing defaults for the power-gated IO requester
package io_pg_pkg;

  localparam int DATA_W_DEF       = 8;
  localparam int WAKE_SETTLE_DEF  = 2;
  localparam int RD_LATENCY_DEF   = 1;
  localparam int WAKE_TIMEOUT_DEF = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAKE,
    ST_SETTLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_RESP
  } pg_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/io_pg_timer.sv
// rtl/io_pg_timer.sv - loadable down-counter that stops at zero and flags done
module io_pg_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/io_pg_requester.sv
// rtl/io_pg_requester.sv - host-side initiator that wakes a power-gated IO controller and issues one access
module io_pg_requester
  import io_pg_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int WAKE_SETTLE  = WAKE_SETTLE_DEF,
  parameter int RD_LATENCY   = RD_LATENCY_DEF,
  parameter int WAKE_TIMEOUT = WAKE_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [DATA_W-1:0] io_in,
  output logic              io_write_en,
  output logic              io_read_request,
  input  logic [DATA_W-1:0] io_out,
  input  logic              io_power_gated,
  input  logic              io_idle_detect,
  output logic [7:0]        wake_count
);

  localparam int TIMER_W = $clog2(max3(WAKE_TIMEOUT, WAKE_SETTLE, RD_LATENCY) + 1);
  // Load values are one less where the count must cover the cycle of entry itself.
  localparam logic [TIMER_W-1:0] TO_LOAD     = TIMER_W'(WAKE_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'((WAKE_SETTLE > 0) ? WAKE_SETTLE - 1 : 0);
  localparam logic [TIMER_W-1:0] RD_LOAD     = TIMER_W'(RD_LATENCY);

  pg_state_t          state;
  logic               op_write;
  logic [DATA_W-1:0]  op_wdata;
  logic               go_wake;
  logic               go_settle;
  logic               go_capture;
  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic               tmr_done;
  logic               unused_idle;

  assign unused_idle = io_idle_detect;

  always_comb begin
    go_wake    = ((state == ST_IDLE) && req_valid && req_ready && io_power_gated) ||
                 ((state == ST_SETTLE) && io_power_gated);
    go_settle  = (state == ST_WAKE) && !io_power_gated && (WAKE_SETTLE != 0);
    go_capture = (state == ST_ISSUE) && !op_write;
    tmr_load   = go_wake || go_settle || go_capture;
    tmr_val    = go_wake ? TO_LOAD : (go_settle ? SETTLE_LOAD : RD_LOAD);
  end

  io_pg_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= ST_IDLE;
      req_ready       <= 1'b1;
      rsp_valid       <= 1'b0;
      rsp_err         <= 1'b0;
      rsp_rdata       <= '0;
      io_in           <= '0;
      io_write_en     <= 1'b0;
      io_read_request <= 1'b0;
      wake_count      <= '0;
      op_write        <= 1'b0;
      op_wdata        <= '0;
    end else begin
      io_write_en     <= 1'b0;
      io_read_request <= 1'b0;
      // A read strobe doubles as the non-destructive wake pulse on every WAKE entry.
      if (go_wake) begin
        io_read_request <= 1'b1;
        if (wake_count != 8'hff) wake_count <= wake_count + 8'd1;
      end
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            op_write  <= req_write;
            op_wdata  <= req_wdata;
            req_ready <= 1'b0;
            state     <= io_power_gated ? ST_WAKE : ST_ISSUE;
          end
        end
        ST_WAKE: begin
          if (!io_power_gated) begin
            state <= (WAKE_SETTLE == 0) ? ST_ISSUE : ST_SETTLE;
          end else if (tmr_done) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= ST_RESP;
          end
        end
        ST_SETTLE: begin
          if (io_power_gated) state <= ST_WAKE;
          else if (tmr_done)  state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (op_write) begin
            io_in       <= op_wdata;
            io_write_en <= 1'b1;
            rsp_rdata   <= op_wdata;
            state       <= ST_RESP;
          end else begin
            io_read_request <= 1'b1;
            state           <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (tmr_done) begin
            rsp_rdata <= io_out;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_pg_requester.sv
// tb/tb_io_pg_requester.sv - directed self-checking bench for io_pg_requester
module tb_io_pg_requester;

  localparam int WS = 2;
  localparam int RL = 1;
  localparam int WT = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_ready, req_write;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_ready, rsp_err;
  logic [7:0] rsp_rdata;
  logic [7:0] io_in, io_out;
  logic       io_write_en, io_read_request, io_power_gated, io_idle_detect;
  logic [7:0] wake_count;
  logic [7:0] mem;

  int n_checks = 0;
  int n_errors = 0;
  int wr_hi = 0;
  int rd_hi = 0;

  io_pg_requester #(
    .DATA_W(8), .WAKE_SETTLE(WS), .RD_LATENCY(RL), .WAKE_TIMEOUT(WT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_wdata       (req_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_rdata       (rsp_rdata),
    .rsp_err         (rsp_err),
    .io_in           (io_in),
    .io_write_en     (io_write_en),
    .io_read_request (io_read_request),
    .io_out          (io_out),
    .io_power_gated  (io_power_gated),
    .io_idle_detect  (io_idle_detect),
    .wake_count      (wake_count)
  );

  always #5 clk = ~clk;

  // IO controller: one-entry store, registered read data, ignores strobes while gated
  always @(posedge clk) begin
    if (io_write_en && !io_power_gated) mem <= io_in;
    if (io_read_request && !io_power_gated) io_out <= mem;
  end

  always @(negedge clk) begin
    if (io_write_en) wr_hi <= wr_hi + 1;
    if (io_read_request) rd_hi <= rd_hi + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_req(input logic wr, input logic [7:0] wd,
                         output int lat, output logic [7:0] rd, output logic er);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check("rsp_valid_seen", 32'(rsp_valid), 1);
    lat = lat - 1;
    rd  = rsp_rdata;
    er  = rsp_err;
    @(negedge clk);
    check("back_to_idle", {30'd0, req_ready, rsp_valid}, 2'b10);
  endtask

  task automatic wait_pulse(input string tag);
    int n = 0;
    while (!io_read_request && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(io_read_request), 1);
  endtask

  task automatic gate_model(input bit reassert, output int gap);
    gap = 0;
    wait_pulse("wake_pulse1");
    repeat (3) @(negedge clk);
    io_power_gated = 1'b0;
    if (reassert) begin
      @(negedge clk);
      io_power_gated = 1'b1;
      wait_pulse("wake_pulse2");
      repeat (2) @(negedge clk);
      io_power_gated = 1'b0;
    end else begin
      do begin
        @(negedge clk);
        gap++;
      end while (!io_read_request && gap < 40);
    end
  endtask

  int         lat, gap, w0, r0;
  logic [7:0] rd;
  logic       er;
  logic       seen, stable;

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_wdata = 8'h00;
    rsp_ready = 1'b1; io_power_gated = 1'b0; io_idle_detect = 1'b0;
    mem = 8'h00; io_out = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_ctl", {27'd0, req_ready, rsp_valid, rsp_err, io_write_en, io_read_request}, 5'b10000);
    check("reset_data", {16'd0, rsp_rdata, io_in}, 0);
    check("reset_wake_count", 32'(wake_count), 0);
    reset = 1'b1;
    @(negedge clk);

    // 1: ungated write 0xA5
    w0 = wr_hi; r0 = rd_hi;
    run_req(1'b1, 8'hA5, lat, rd, er);
    check("t1_latency", 32'(lat), 2);
    check("t1_rdata", 32'(rd), 32'hA5);
    check("t1_err", 32'(er), 0);
    check("t1_io_in", 32'(io_in), 32'hA5);
    check("t1_wr_strobe_cycles", 32'(wr_hi - w0), 1);
    check("t1_rd_strobe_cycles", 32'(rd_hi - r0), 0);
    check("t1_wake_count", 32'(wake_count), 0);

    // 2: write 0x3C then ungated read
    run_req(1'b1, 8'h3C, lat, rd, er);
    w0 = wr_hi; r0 = rd_hi;
    run_req(1'b0, 8'hFF, lat, rd, er);
    check("t2_latency", 32'(lat), 3);
    check("t2_rdata", 32'(rd), 32'h3C);
    check("t2_rd_strobe_cycles", 32'(rd_hi - r0), 1);
    check("t2_no_write", 32'(wr_hi - w0), 0);
    check("t2_io_in_held", 32'(io_in), 32'h3C);

    // 3: gated read, gate drops 3 cycles after the wake pulse
    r0 = rd_hi;
    io_power_gated = 1'b1;
    fork
      run_req(1'b0, 8'h00, lat, rd, er);
      gate_model(1'b0, gap);
    join
    check("t3_strobe_gap", 32'(gap), 4);
    check("t3_latency", 32'(lat), 9);
    check("t3_rdata", 32'(rd), 32'h3C);
    check("t3_err", 32'(er), 0);
    check("t3_wake_count", 32'(wake_count), 1);
    check("t3_rd_strobe_cycles", 32'(rd_hi - r0), 2);

    // 4: gate stuck high -> timeout error
    r0 = rd_hi;
    io_power_gated = 1'b1;
    run_req(1'b0, 8'h00, lat, rd, er);
    io_power_gated = 1'b0;
    check("t4_latency", 32'(lat), 15);
    check("t4_err", 32'(er), 1);
    check("t4_rdata", 32'(rd), 0);
    check("t4_wake_count", 32'(wake_count), 2);
    check("t4_rd_strobe_cycles", 32'(rd_hi - r0), 1);

    // 5: gate re-asserts during SETTLE, write completes after second wake
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    w0 = wr_hi; r0 = rd_hi;
    io_power_gated = 1'b1;
    fork
      run_req(1'b1, 8'h5A, lat, rd, er);
      gate_model(1'b1, gap);
    join
    check("t5_latency", 32'(lat), 12);
    check("t5_rdata", 32'(rd), 32'h5A);
    check("t5_err", 32'(er), 0);
    check("t5_wake_count", 32'(wake_count), 2);
    check("t5_rd_strobe_cycles", 32'(rd_hi - r0), 2);
    check("t5_wr_strobe_cycles", 32'(wr_hi - w0), 1);
    check("t5_mem", 32'(mem), 32'h5A);

    // 6a: reset during CAPTURE aborts with no response
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t6_async_ctl", {27'd0, req_ready, rsp_valid, rsp_err, io_write_en, io_read_request}, 5'b10000);
    check("t6_async_wake_count", 32'(wake_count), 0);
    check("t6_async_io_in", 32'(io_in), 0);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("t6_no_rsp_after_abort", 32'(seen), 0);

    // 6b: response held while rsp_ready low; a pending request is not accepted
    w0 = wr_hi;
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_wdata = 8'h77;
    @(posedge clk);
    @(negedge clk);
    req_wdata = 8'h11;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("t6_rsp_seen", 32'(rsp_valid), 1);
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== 8'h77 || rsp_err || req_ready) stable = 1'b0;
    end
    check("t6_rsp_stable", 32'(stable), 1);
    check("t6_single_write", 32'(wr_hi - w0), 1);
    check("t6_mem", 32'(mem), 32'h77);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t6_release", {30'd0, req_ready, rsp_valid}, 2'b10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
